// File: rtl/read_operands.sv
// read_operands: operand-fetch stage for the 8-entry register file.
// Captures a fetch request from the decoder, reads the two source
// registers (with bypass of the value committing this cycle), and holds
// the latched operands for the datapath until acknowledged. An 8-bit
// scoreboard tracks registers with a write still in flight; a fetch that
// needs such a register waits until the write commits.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   reg0..reg7          current register-file contents
//   write/writenum/data_in  register-file commit (also used for bypass)
//   req, rnA, rnB, useB, mark, marknum   fetch request (sampled in IDLE)
//   ack                 datapath consumes A/B
//   A, B, valid, busy   latched operands and handshake status
//   sb                  scoreboard, bit i = write pending on reg i
module read_operands #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] reg0,
  input  logic [width-1:0] reg1,
  input  logic [width-1:0] reg2,
  input  logic [width-1:0] reg3,
  input  logic [width-1:0] reg4,
  input  logic [width-1:0] reg5,
  input  logic [width-1:0] reg6,
  input  logic [width-1:0] reg7,
  input  logic             write,
  input  logic [2:0]       writenum,
  input  logic [width-1:0] data_in,
  input  logic             req,
  input  logic [2:0]       rnA,
  input  logic [2:0]       rnB,
  input  logic             useB,
  input  logic             mark,
  input  logic [2:0]       marknum,
  input  logic             ack,
  output logic [width-1:0] A,
  output logic [width-1:0] B,
  output logic             valid,
  output logic             busy,
  output logic [7:0]       sb
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t           state_q;
  logic [width-1:0] a_q, b_q;
  logic             valid_q, busy_q;
  logic [7:0]       sb_q, sb_d;

  // captured request
  logic [2:0]       rna_q, rnb_q, marknum_q;
  logic             useb_q, mark_q;

  logic [7:0][width-1:0] regs;
  assign regs = {reg7, reg6, reg5, reg4, reg3, reg2, reg1, reg0};

  // In IDLE the live request drives the decision (it is captured the same
  // edge); in WAIT only the captured copy matters.
  logic [2:0]       a_sel, b_sel, mn_sel;
  logic             ub_sel, mk_sel;
  logic             hit_a, hit_b, hazard, fetch, accept;
  logic [width-1:0] op_a, op_b;

  always_comb begin
    a_sel  = rna_q;
    b_sel  = rnb_q;
    ub_sel = useb_q;
    mk_sel = mark_q;
    mn_sel = marknum_q;
    if (state_q == S_IDLE) begin
      a_sel  = rnA;
      b_sel  = rnB;
      ub_sel = useB;
      mk_sel = mark;
      mn_sel = marknum;
    end
    hit_a  = write && (writenum == a_sel);
    hit_b  = write && (writenum == b_sel);
    // a busy bit being cleared this cycle is satisfied by the bypass
    hazard = (sb_q[a_sel] && !hit_a) || (ub_sel && sb_q[b_sel] && !hit_b);
    fetch  = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);
    accept = fetch && !hazard;
    op_a   = hit_a ? data_in : regs[a_sel];
    op_b   = '0;
    if (ub_sel) op_b = hit_b ? data_in : regs[b_sel];
    // clear first, then set: a new producer marked this cycle stays pending
    sb_d = sb_q;
    if (write)           sb_d[writenum] = 1'b0;
    if (accept && mk_sel) sb_d[mn_sel]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sb_q      <= '0;
      rna_q     <= '0;
      rnb_q     <= '0;
      useb_q    <= 1'b0;
      mark_q    <= 1'b0;
      marknum_q <= '0;
    end else begin
      sb_q <= sb_d;
      case (state_q)
        S_IDLE: if (req) begin
          rna_q     <= rnA;
          rnb_q     <= rnB;
          useb_q    <= useB;
          mark_q    <= mark;
          marknum_q <= marknum;
          busy_q    <= 1'b1;
          if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: if (accept) begin
          a_q     <= op_a;
          b_q     <= op_b;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: if (ack) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign sb    = sb_q;

endmodule

// File: tb/tb_read_operands.sv
// Directed bench for read_operands: a table of no-hazard fetches with
// hand-computed operands, followed by sequences for stall/bypass,
// scoreboard collisions and reset in the middle of an operation.
module tb_read_operands;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        req;
  logic [2:0]  rnA, rnB;
  logic        useB, mark;
  logic [2:0]  marknum;
  logic        ack;
  logic [15:0] A, B;
  logic        valid, busy;
  logic [7:0]  sb;

  int n_vec = 0;
  int n_err = 0;

  read_operands #(.width(16)) dut (
    .clk(clk), .reset(reset),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
    .write(write), .writenum(writenum), .data_in(data_in),
    .req(req), .rnA(rnA), .rnB(rnB), .useB(useB),
    .mark(mark), .marknum(marknum), .ack(ack),
    .A(A), .B(B), .valid(valid), .busy(busy), .sb(sb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a, b;
    logic        ub, wr;
    logic [2:0]  wn;
    logic [15:0] d;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic ub,
                       input logic mk, input logic [2:0] mn,
                       input logic wr, input logic [2:0] wn, input logic [15:0] d);
    req = 1'b1; rnA = a; rnB = b; useB = ub; mark = mk; marknum = mn;
    write = wr; writenum = wn; data_in = d;
    tick();
    req = 1'b0; mark = 1'b0; write = 1'b0;
    rnA = 3'd7; rnB = 3'd7; useB = 1'b1; // scramble live inputs
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    reg0 = 16'h0A0A; reg1 = 16'h1111; reg2 = 16'h2222; reg3 = 16'h1234;
    reg4 = 16'h4444; reg5 = 16'h00FF; reg6 = 16'h6666; reg7 = 16'h7777;
    reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0; req = 1'b0;
    rnA = '0; rnB = '0; useB = 1'b0; mark = 1'b0; marknum = '0; ack = 1'b0;

    tbl[0] = '{3'd3, 3'd5, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'h00FF};
    tbl[1] = '{3'd0, 3'd7, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0A0A, 16'h7777};
    tbl[2] = '{3'd7, 3'd7, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h7777, 16'h0000};
    tbl[3] = '{3'd1, 3'd2, 1'b1, 1'b1, 3'd2, 16'hABCD, 16'h1111, 16'hABCD};
    tbl[4] = '{3'd4, 3'd4, 1'b1, 1'b1, 3'd4, 16'h5A5A, 16'h5A5A, 16'h5A5A};
    tbl[5] = '{3'd6, 3'd1, 1'b1, 1'b1, 3'd3, 16'hFFFF, 16'h6666, 16'h1111};

    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_sb",    {24'd0, sb},    32'd0);
    chk("rst_A",     {16'd0, A},     32'd0);
    chk("rst_B",     {16'd0, B},     32'd0);
    tick();
    reset = 1'b0;
    tick();

    // table of single-cycle fetches
    for (int i = 0; i < 6; i++) begin
      fetch(tbl[i].a, tbl[i].b, tbl[i].ub, 1'b0, 3'd0, tbl[i].wr, tbl[i].wn, tbl[i].d);
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, 32'd1);
      chk($sformatf("v%0d_busy", i),  {31'd0, busy},  32'd1);
      chk($sformatf("v%0d_A", i),     {16'd0, A},     {16'd0, tbl[i].exp_a});
      chk($sformatf("v%0d_B", i),     {16'd0, B},     {16'd0, tbl[i].exp_b});
      do_ack();
      chk($sformatf("v%0d_ack_valid", i), {31'd0, valid}, 32'd0);
      chk($sformatf("v%0d_ack_busy", i),  {31'd0, busy},  32'd0);
    end

    // hold stable without ack, ack outside HOLD ignored afterwards
    fetch(3'd3, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_A", {16'd0, A}, 32'h1234);
      chk("hold_B", {16'd0, B}, 32'h00FF);
      chk("hold_valid", {31'd0, valid}, 32'd1);
    end
    do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);

    // stall and bypass
    fetch(3'd0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0);
    chk("mark2_sb", {24'd0, sb}, 32'h04);
    do_ack();
    fetch(3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("wait_valid", {31'd0, valid}, 32'd0);
      chk("wait_busy",  {31'd0, busy},  32'd1);
      tick();
    end
    write = 1'b1; writenum = 3'd2; data_in = 16'hBEEF;
    tick();
    write = 1'b0;
    chk("bypass_valid", {31'd0, valid}, 32'd1);
    chk("bypass_A",     {16'd0, A},     32'hBEEF);
    chk("bypass_sb",    {24'd0, sb},    32'h00);
    do_ack();

    // same-cycle bypass in IDLE
    fetch(3'd0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 16'h0);
    chk("mark6_sb", {24'd0, sb}, 32'h40);
    do_ack();
    fetch(3'd6, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 16'h0042);
    chk("idle_byp_valid", {31'd0, valid}, 32'd1);
    chk("idle_byp_A",     {16'd0, A},     32'h0042);
    chk("idle_byp_sb",    {24'd0, sb},    32'h00);
    do_ack();

    // useB=0 ignores a pending rnB
    fetch(3'd0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0);
    do_ack();
    fetch(3'd0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("nob_valid", {31'd0, valid}, 32'd1);
    chk("nob_A",     {16'd0, A},     32'h0A0A);
    chk("nob_B",     {16'd0, B},     32'h0000);
    chk("nob_sb",    {24'd0, sb},    32'h02);
    do_ack();
    write = 1'b1; writenum = 3'd1; tick(); write = 1'b0;
    chk("clr1_sb", {24'd0, sb}, 32'h00);
    write = 1'b1; writenum = 3'd5; tick(); write = 1'b0;
    chk("clr_unmarked_sb", {24'd0, sb}, 32'h00);

    // set/clear collision: set wins
    fetch(3'd0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0);
    do_ack();
    fetch(3'd0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 3'd4, 16'h9999);
    chk("coll_valid", {31'd0, valid}, 32'd1);
    chk("coll_sb",    {24'd0, sb},    32'h10);
    do_ack();
    write = 1'b1; writenum = 3'd4; tick(); write = 1'b0;

    // reset in WAIT
    fetch(3'd0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0);
    do_ack();
    fetch(3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("rw_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk("rw_valid", {31'd0, valid}, 32'd0);
    chk("rw_busy",  {31'd0, busy},  32'd0);
    chk("rw_sb",    {24'd0, sb},    32'h00);
    chk("rw_A",     {16'd0, A},     32'h0000);
    reset = 1'b0;
    tick();
    fetch(3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("rw_fresh_valid", {31'd0, valid}, 32'd1);
    chk("rw_fresh_A",     {16'd0, A},     32'h2222);

    // reset in HOLD
    reset = 1'b1; #1;
    chk("rh_valid", {31'd0, valid}, 32'd0);
    chk("rh_busy",  {31'd0, busy},  32'd0);
    chk("rh_A",     {16'd0, A},     32'h0000);
    chk("rh_B",     {16'd0, B},     32'h0000);
    reset = 1'b0;
    tick();
    fetch(3'd3, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("rh_fresh_A", {16'd0, A}, 32'h1234);
    chk("rh_fresh_B", {16'd0, B}, 32'h00FF);
    do_ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
